// File: rtl/lsu_align_unit_if.sv
// Pipeline request/response and data-memory bus signals of the load/store alignment unit.
// The master modport is the alignment unit; the slave modport is the pipeline plus memory.
interface lsu_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
           mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
           mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: lane steering, misaligned-access splitting into two
// aligned bus beats, and merge plus sign/zero extension of load data.
module lsu_align_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  lsu_align_unit_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              we_q;
  logic              split_q;
  logic [2:0]        op_q;
  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cap_lo;
  logic              load_rd;

  function automatic logic [DATA_W-1:0] extend_ld(input logic [DATA_W-1:0] v,
                                                   input logic [2:0] op);
    logic [DATA_W-1:0] r;
    case (op)
      3'b000:  begin r = {DATA_W{v[7]}};  r[7:0]  = v[7:0];  end
      3'b001:  begin r = '0;              r[7:0]  = v[7:0];  end
      3'b010:  begin r = {DATA_W{v[15]}}; r[15:0] = v[15:0]; end
      3'b011:  begin r = '0;              r[15:0] = v[15:0]; end
      3'b100:  begin r = {DATA_W{v[31]}}; r[31:0] = v[31:0]; end
      3'b101:  begin r = '0;              r[31:0] = v[31:0]; end
      default: r = v;
    endcase
    return r;
  endfunction

  logic             accept;
  logic [3:0]       dec_size;
  logic [OFF_W-1:0] dec_off;
  logic [4:0]       dec_end;
  logic             dec_split;
  logic             dec_misal;
  logic             dec_illegal;

  always_comb begin
    accept   = bus.req_valid && (state_q == IDLE);
    dec_off  = bus.req_addr[OFF_W-1:0];
    case (bus.req_op[2:1])
      2'b00:   dec_size = 4'd1;
      2'b01:   dec_size = 4'd2;
      2'b10:   dec_size = 4'd4;
      default: dec_size = 4'd8;
    endcase
    dec_end     = 5'(dec_off) + 5'(dec_size);
    dec_split   = dec_end > 5'(BYTES);
    // Without splitting support any non-naturally-aligned access is rejected, split or not.
    dec_misal   = |(4'(dec_off) & (dec_size - 4'd1));
    dec_illegal = (bus.req_op == 3'b111) ||
                  ((DATA_W == 32) && ((bus.req_op == 3'b101) || (bus.req_op == 3'b110)));
  end

  logic [2*BYTES-1:0]  lane_mask;
  logic [2*BYTES-1:0]  be_full;
  logic [2*DATA_W-1:0] wd_full;
  logic [DATA_W-1:0]   lo_sel;
  logic [2*DATA_W-1:0] merged;
  logic [DATA_W-1:0]   ld_result;

  always_comb begin
    lane_mask = (2*BYTES)'((16'h1 << size_q) - 16'h1);
    be_full   = lane_mask << off_q;
    wd_full   = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    // The second beat's data arrives on mem_rdata in the same cycle the result is registered.
    lo_sel    = (state_q == WAIT1) ? bus.mem_rdata : lo_q;
    merged    = {bus.mem_rdata, lo_sel} >> {off_q, 3'b000};
    ld_result = extend_ld(merged[DATA_W-1:0], op_q);
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    rdata_d       = '0;
    cap_lo        = 1'b0;
    load_rd       = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          err_d   = dec_illegal || (!MISALIGN_EN && dec_misal);
          state_d = err_d ? RESP : REQ1;
          load_rd = 1'b1;
        end
      end
      REQ1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_be    = be_full[BYTES-1:0];
        bus.mem_wdata = wd_full[DATA_W-1:0];
        if (bus.mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
          cap_lo = 1'b1;
          if (bus.mem_err) begin
            err_d   = 1'b1;
            state_d = RESP;
            load_rd = 1'b1;
          end else if (split_q) begin
            state_d = REQ2;
          end else begin
            state_d = RESP;
            load_rd = 1'b1;
            rdata_d = we_q ? '0 : ld_result;
          end
        end
      end
      REQ2: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q + ADDR_W'(BYTES);
        bus.mem_be    = be_full[2*BYTES-1:BYTES];
        bus.mem_wdata = wd_full[2*DATA_W-1:DATA_W];
        if (bus.mem_gnt) state_d = WAIT2;
      end
      WAIT2: begin
        if (bus.mem_rvalid) begin
          err_d   = err_q | bus.mem_err;
          state_d = RESP;
          load_rd = 1'b1;
          rdata_d = (we_q || bus.mem_err) ? '0 : ld_result;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_err   = bus.rsp_valid & err_q;

  // Control state: cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Request decode and data buffers: only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      op_q    <= bus.req_op;
      size_q  <= dec_size;
      off_q   <= dec_off;
      split_q <= dec_split;
      addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= bus.req_wdata;
    end
    if (cap_lo)  lo_q    <= bus.mem_rdata;
    if (load_rd) rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: one instance with misaligned splitting, one without.
module tb_lsu_align_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu_align_unit_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  lsu_align_unit_if #(.DATA_W(32), .ADDR_W(32)) b0 ();

  lsu_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(b1));
  lsu_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    check("req_ready_before_accept", b1.req_ready, 1);
    b1.req_valid = 1'b1; b1.req_we = we; b1.req_op = op;
    b1.req_addr = addr; b1.req_wdata = wdata;
    tick();
    b1.req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic we, input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err);
    int n = 0;
    while (b1.mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_req"}, b1.mem_req, 1);
    check({tag, "_addr"}, b1.mem_addr, addr);
    check({tag, "_be"}, b1.mem_be, be);
    check({tag, "_we"}, b1.mem_we, we);
    if (we) check({tag, "_wdata"}, b1.mem_wdata, wdata);
    b1.mem_gnt = 1'b1;
    tick();
    b1.mem_gnt = 1'b0;
    check({tag, "_req_low_in_wait"}, b1.mem_req, 0);
    b1.mem_rvalid = 1'b1; b1.mem_rdata = rdata; b1.mem_err = err;
    tick();
    b1.mem_rvalid = 1'b0; b1.mem_rdata = '0; b1.mem_err = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [31:0] rdata, input logic err);
    int n = 0;
    while (b1.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_rsp_valid"}, b1.rsp_valid, 1);
    check({tag, "_rdata"}, b1.rsp_rdata, rdata);
    check({tag, "_err"}, b1.rsp_err, err);
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    check({tag, "_back_idle"}, {b1.rsp_valid, b1.req_ready}, 2'b01);
  endtask

  task automatic reject0(input string tag, input logic [2:0] op, input logic [31:0] addr);
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_op = op; b0.req_addr = addr;
    tick();
    b0.req_valid = 1'b0;
    check({tag, "_no_req"}, b0.mem_req, 0);
    check({tag, "_rsp_valid"}, b0.rsp_valid, 1);
    check({tag, "_err"}, b0.rsp_err, 1);
    check({tag, "_rdata"}, b0.rsp_rdata, 0);
    b0.rsp_ready = 1'b1;
    tick();
    b0.rsp_ready = 1'b0;
    check({tag, "_idle"}, b0.req_ready, 1);
  endtask

  initial begin
    b1.req_valid = 0; b1.req_we = 0; b1.req_op = 0; b1.req_addr = 0; b1.req_wdata = 0;
    b1.rsp_ready = 0; b1.mem_gnt = 0; b1.mem_rvalid = 0; b1.mem_rdata = 0; b1.mem_err = 0;
    b0.req_valid = 0; b0.req_we = 0; b0.req_op = 0; b0.req_addr = 0; b0.req_wdata = 0;
    b0.rsp_ready = 0; b0.mem_gnt = 0; b0.mem_rvalid = 0; b0.mem_rdata = 0; b0.mem_err = 0;

    #2;
    check("reset_req_ready", b1.req_ready, 1);
    check("reset_outputs", {b1.rsp_valid, b1.rsp_err, b1.mem_req, b1.mem_we, b1.mem_be},
          8'h00);
    check("reset_rdata", b1.rsp_rdata, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Aligned lw with latency checks.
    issue(1'b0, 3'b100, 32'h1000, 32'h0);
    check("t1_req_at_T1", b1.mem_req, 1);
    beat("t1", 32'h1000, 4'b1111, 1'b0, 32'h0, 32'h8899AABB, 1'b0);
    check("t1_rsp_at_T3", b1.rsp_valid, 1);
    check("t1_no_second_req", b1.mem_req, 0);
    resp("t1", 32'h8899AABB, 1'b0);

    // Byte / halfword extension.
    issue(1'b0, 3'b000, 32'h2003, 32'h0);
    beat("lb", 32'h2000, 4'b1000, 1'b0, 32'h0, 32'h80FF1234, 1'b0);
    resp("lb", 32'hFFFFFF80, 1'b0);
    issue(1'b0, 3'b001, 32'h2003, 32'h0);
    beat("lbu", 32'h2000, 4'b1000, 1'b0, 32'h0, 32'h80FF1234, 1'b0);
    resp("lbu", 32'h00000080, 1'b0);
    issue(1'b0, 3'b011, 32'h2002, 32'h0);
    beat("lhu", 32'h2000, 4'b1100, 1'b0, 32'h0, 32'h80FF1234, 1'b0);
    resp("lhu", 32'h000080FF, 1'b0);
    issue(1'b0, 3'b010, 32'h2002, 32'h0);
    beat("lh", 32'h2000, 4'b1100, 1'b0, 32'h0, 32'h80FF1234, 1'b0);
    resp("lh", 32'hFFFF80FF, 1'b0);

    // Split lw.
    issue(1'b0, 3'b100, 32'h1003, 32'h0);
    beat("slw1", 32'h1000, 4'b1000, 1'b0, 32'h0, 32'h44332211, 1'b0);
    beat("slw2", 32'h1004, 4'b0111, 1'b0, 32'h0, 32'h88776655, 1'b0);
    resp("slw", 32'h77665544, 1'b0);

    // Split sh and aligned/byte stores.
    issue(1'b1, 3'b010, 32'h1003, 32'h0000BEEF);
    beat("ssh1", 32'h1000, 4'b1000, 1'b1, 32'hEF000000, 32'h0, 1'b0);
    beat("ssh2", 32'h1004, 4'b0001, 1'b1, 32'h000000BE, 32'h0, 1'b0);
    resp("ssh", 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h3001, 32'h000000A5);
    beat("sb", 32'h3000, 4'b0010, 1'b1, 32'h0000A500, 32'hFFFFFFFF, 1'b0);
    resp("sb", 32'h0, 1'b0);

    // Rejections with splitting disabled, and illegal ops.
    reject0("m0_lh", 3'b010, 32'h1001);
    reject0("m0_ld", 3'b110, 32'h1000);
    issue(1'b0, 3'b111, 32'h1000, 32'h0);
    check("op111_no_req", b1.mem_req, 0);
    resp("op111", 32'h0, 1'b1);

    // Bus error on first beat of a split load.
    issue(1'b0, 3'b100, 32'h1003, 32'h0);
    beat("berr", 32'h1000, 4'b1000, 1'b0, 32'h0, 32'h44332211, 1'b1);
    check("berr_no_second_req", b1.mem_req, 0);
    resp("berr", 32'h0, 1'b1);

    // Stray rvalid in IDLE is ignored.
    b1.mem_rvalid = 1'b1; b1.mem_rdata = 32'hDEADBEEF;
    tick();
    b1.mem_rvalid = 1'b0;
    check("stray_rvalid", {b1.rsp_valid, b1.req_ready}, 2'b01);

    // Backpressure.
    issue(1'b0, 3'b100, 32'h1000, 32'h0);
    beat("bp", 32'h1000, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {b1.rsp_valid, b1.req_ready, b1.rsp_err, b1.rsp_rdata},
            {3'b100, 32'hCAFEF00D});
      tick();
    end
    resp("bp", 32'hCAFEF00D, 1'b0);

    // Reset while REQ2 drives the bus.
    issue(1'b0, 3'b100, 32'h1003, 32'h0);
    beat("rq1", 32'h1000, 4'b1000, 1'b0, 32'h0, 32'h44332211, 1'b0);
    check("rq2_req", b1.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_req2_mem_req", b1.mem_req, 0);
    check("rst_req2_ready", b1.req_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Reset during WAIT2.
    issue(1'b0, 3'b100, 32'h1003, 32'h0);
    beat("rw1", 32'h1000, 4'b1000, 1'b0, 32'h0, 32'h44332211, 1'b0);
    check("rw2_req", b1.mem_req, 1);
    b1.mem_gnt = 1'b1;
    tick();
    b1.mem_gnt = 1'b0;
    check("rw2_in_wait", {b1.mem_req, b1.req_ready, b1.rsp_valid}, 3'b000);
    #2 rst = 1'b1;
    #1;
    check("rst_wait2", {b1.mem_req, b1.rsp_valid, b1.rsp_err, b1.req_ready}, 4'b0001);
    tick();
    rst = 1'b0;
    tick();
    issue(1'b0, 3'b100, 32'h1000, 32'h0);
    beat("post", 32'h1000, 4'b1111, 1'b0, 32'h0, 32'h01020304, 1'b0);
    resp("post", 32'h01020304, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
